// File: rtl/coincident_arb_pkg.sv
// Shared types and helpers for the coincident event arbiter.
// rr_next is the round-robin search used by the picker.
package coincident_arb_pkg;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  localparam int MAX_REQ = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set index strictly after ptr, wrapping modulo n; returns ptr if mask is empty.
  // Scanning from the far end lets the nearest hit overwrite the result last.
  function automatic int rr_next(input logic [MAX_REQ-1:0] mask, input int ptr, input int n);
    int r;
    int j;
    r = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k <= n && j < MAX_REQ && mask[j[3:0]]) r = j;
    end
    return r;
  endfunction

endpackage

// File: rtl/coincident_event_arbiter_rr_pick.sv
// Combinational round-robin picker over the nonzero-counter mask.
module rr_pick
  import coincident_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] mask_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             any_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [MAX_REQ-1:0] mask_w;

  always_comb begin
    mask_w = '0;
    mask_w[N_REQ-1:0] = mask_i;
  end

  assign any_o = |mask_i;
  assign idx_o = ID_W'(rr_next(mask_w, int'(ptr_i), N_REQ));

endmodule

// File: rtl/coincident_event_arbiter.sv
// Counts per-source events (coincident ones included) and hands them one at a
// time to a single consumer over valid/ready, in round-robin order.
module coincident_event_arbiter
  import coincident_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] evt,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  input  logic             out_ready,
  output logic             pending_any,
  output logic [N_REQ-1:0] overflow,
  input  logic             overflow_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]            nz, ovf_set, overflow_q;
  state_t                      state_q;
  logic                        out_valid_q, pending_q;
  logic [ID_W-1:0]             out_id_q, ptr_q, pick_idx;
  logic                        pick_any, xfer, load, dec, valid_nxt, cnt_nz_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) nz[i] = |cnt_q[i];
  end

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .mask_i (nz),
    .ptr_i  (ptr_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign xfer = out_valid_q & out_ready;
  // The picker only looks at registered counts, so this cycle's events wait a cycle.
  assign load = pick_any & ((state_q == IDLE) | xfer);
  assign valid_nxt = load | (out_valid_q & ~xfer);

  always_comb begin
    cnt_d    = cnt_q;
    ovf_set  = '0;
    cnt_nz_d = 1'b0;
    dec      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      dec = load && (pick_idx == ID_W'(i));
      if (evt[i] && !dec) begin
        if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (dec && !evt[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      cnt_nz_d = cnt_nz_d | (|cnt_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      overflow_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= (overflow_q & ~{N_REQ{overflow_clr}}) | ovf_set;
      pending_q  <= cnt_nz_d | valid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      ptr_q       <= ID_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q     <= PRESENT;
            out_valid_q <= 1'b1;
            out_id_q    <= pick_idx;
            ptr_q       <= pick_idx;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (pick_any) begin
              out_id_q <= pick_idx;
              ptr_q    <= pick_idx;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign pending_any = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/coincident_event_arbiter.md
Name: coincident_event_arbiter

Overview:
- Round-robin scheduler for event sources that may fire on the same clock edge (e.g. two strobes driven high in one timestep).
- Every input event is counted per source, so none are lost on coincidence.
- Events are presented one at a time to a single consumer over a valid/ready handshake.
- Sits between the event-generating stimulus logic and one shared consumer (monitor/scoreboard port) in the test-case toplevels.

Parameters:
- N_REQ, 2, number of event sources (2..16).
- CNT_W, 4, width of each per-source pending counter.
- ID_W, $clog2(N_REQ) (min 1), width of out_id.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- evt  in  N_REQ  per-source event; high in a cycle = one event from that source.
- out_valid  out  1  an event is being presented.
- out_id  out  ID_W  source index of the presented event.
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready.
- pending_any  out  1  any pending counter nonzero, or out_valid high.
- overflow  out  N_REQ  sticky per-source flag: an event was dropped at counter saturation.
- overflow_clr  in  1  synchronous clear of all overflow bits.

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_id=0, pending_any=0, overflow=0.
  - All counters=0; state=IDLE; rr pointer=N_REQ-1, so source 0 wins first.
- Counters, per source i each cycle:
  - +1 if evt[i]; -1 if source i is loaded into the output register this cycle.
  - Both in the same cycle: no change.
  - Increment at value 2^CNT_W-1 with no simultaneous decrement: counter holds, overflow[i] set.
  - Never wraps; never goes below 0.
- States IDLE and PRESENT:
  - IDLE: if any counter nonzero, pick source p = first nonzero index searching upward from ptr+1 modulo N_REQ. Set out_id=p, out_valid=1, decrement cnt[p], ptr=p. Go to PRESENT.
  - PRESENT: out_valid=1 and out_id held stable while out_ready=0.
    - On transfer with another counter nonzero: reload the next pick in the same cycle (back-to-back, one event per cycle); stay PRESENT.
    - On transfer with all counters zero: out_valid=0; go to IDLE.
- Latency and throughput:
  - evt at edge t is counted at t. The earliest out_valid is after edge t+1 (counter registered, then picker).
  - Sustained throughput is 1 event/cycle with out_ready held high.
- Picker sees counter values before this cycle's increments. Coincident events on all sources in one cycle give N_REQ transfers in round-robin order from ptr+1.
- overflow_clr and a new overflow in the same cycle: set wins.
- pending_any is a registered OR of (counters nonzero) | out_valid.
- Reset mid-handshake: all pending events discarded; out_valid drops asynchronously.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package coincident_arb_pkg:
  - state_t enum {IDLE, PRESENT}.
  - Function id_width(n) returning max(1, $clog2(n)).
  - Function rr_next(mask, ptr) returning the first set index after ptr, used by both RTL and reference model.
- Sub-module rr_pick:
  - Combinational; inputs mask[N_REQ], ptr[ID_W]; outputs any, idx[ID_W].
  - Instantiated once for the load decision.
- Top keeps counters, state and output register.

Test Plan:
- Reset then idle, evt=0 for 10 cycles -> out_valid=0, pending_any=0, overflow=2'b00 throughout.
- Coincident evt=2'b11 for one cycle, out_ready=1 -> out_valid for exactly 2 consecutive cycles, out_id 0 then 1, then out_valid=0.
- evt=2'b11 every other cycle for 20 cycles (10 pulses per source), out_ready=1 -> 20 transfers total, alternating ids 0,1, no overflow.
- evt[0]=1 for 20 consecutive cycles, out_ready=0 -> out_valid=1 with out_id=0 stable. Counter saturates at 15 and overflow=2'b01. Raising out_ready then yields 16 transfers in total (1 already latched + 15 counted). Pulse overflow_clr -> overflow=0.
- out_ready toggled 1010... with evt=2'b11 each cycle for 8 cycles -> out_id never changes while out_valid & !out_ready; id sequence strictly alternates.
- Assert rst for 1 cycle while out_valid=1 and counters=5,3 -> out_valid=0 immediately; no transfers after release until a new evt.
